// File: rtl/ram_cmd_master_if.sv
// Host request/response and RAM command/reply signals of the RAM command master.
// master: the command sequencer; slave: the host/RAM side that drives the inputs.
interface ram_cmd_master_if #(
  parameter int ADDR_SIZE = 8
);
  logic                   req_valid;
  logic                   req_ready;
  logic                   req_write;
  logic [ADDR_SIZE-1:0]   req_addr;
  logic [ADDR_SIZE-1:0]   req_wdata;
  logic                   rsp_valid;
  logic [ADDR_SIZE-1:0]   rsp_rdata;
  logic                   rsp_timeout;
  logic [ADDR_SIZE+1:0]   ram_din;
  logic                   ram_rx_valid;
  logic [ADDR_SIZE-1:0]   ram_dout;
  logic                   ram_tx_valid;

  modport master (
    input  req_valid, req_write, req_addr, req_wdata, ram_dout, ram_tx_valid,
    output req_ready, rsp_valid, rsp_rdata, rsp_timeout, ram_din, ram_rx_valid
  );

  modport slave (
    output req_valid, req_write, req_addr, req_wdata, ram_dout, ram_tx_valid,
    input  req_ready, rsp_valid, rsp_rdata, rsp_timeout, ram_din, ram_rx_valid
  );
endinterface

// File: rtl/ram_cmd_master.sv
// Turns one host read/write into RAM command words; write responds 3 cycles after accept, read 4+ (timeout-bounded).
// Backpressure: req_ready only in IDLE, requests while busy are ignored; no backpressure on the RAM side.
module ram_cmd_master #(
  parameter int ADDR_SIZE = 8,
  parameter int TIMEOUT   = 15
) (
  input  logic              clk,
  input  logic              rst_n,
  ram_cmd_master_if.master  bus
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    ADDR = 3'd1,
    DATA = 3'd2,
    RCMD = 3'd3,
    WAIT = 3'd4,
    RESP = 3'd5
  } state_t;

  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  state_t                 state;
  state_t                 state_nxt;
  logic [7:0]             cnt;
  logic                   lat_write;
  logic [ADDR_SIZE-1:0]   lat_addr;
  logic [ADDR_SIZE-1:0]   lat_wdata;
  logic [ADDR_SIZE-1:0]   rdata_q;
  logic                   timeout_q;
  logic                   accept;
  logic                   wait_hit;
  logic                   wait_expire;

  always_comb begin
    state_nxt        = state;
    accept           = 1'b0;
    wait_hit         = 1'b0;
    wait_expire      = 1'b0;
    bus.req_ready    = 1'b0;
    bus.rsp_valid    = 1'b0;
    bus.ram_rx_valid = 1'b0;
    bus.ram_din      = '0;
    case (state)
      IDLE: begin
        bus.req_ready = 1'b1;
        if (bus.req_valid) begin
          accept    = 1'b1;
          state_nxt = ADDR;
        end
      end
      ADDR: begin
        bus.ram_rx_valid = 1'b1;
        bus.ram_din      = {(lat_write ? 2'b00 : 2'b10), lat_addr};
        state_nxt        = lat_write ? DATA : RCMD;
      end
      DATA: begin
        bus.ram_rx_valid = 1'b1;
        bus.ram_din      = {2'b01, lat_wdata};
        state_nxt        = RESP;
      end
      RCMD: begin
        bus.ram_rx_valid = 1'b1;
        bus.ram_din      = {2'b11, {ADDR_SIZE{1'b0}}};
        state_nxt        = WAIT;
      end
      WAIT: begin
        // Reply data wins over expiry on the last allowed cycle.
        if (bus.ram_tx_valid) begin
          wait_hit  = 1'b1;
          state_nxt = RESP;
        end else if (cnt == CNT_LAST) begin
          wait_expire = 1'b1;
          state_nxt   = RESP;
        end
      end
      RESP: begin
        bus.rsp_valid = 1'b1;
        state_nxt     = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= 8'd0;
      lat_write <= 1'b0;
      lat_addr  <= '0;
      lat_wdata <= '0;
      rdata_q   <= '0;
      timeout_q <= 1'b0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        lat_write <= bus.req_write;
        lat_addr  <= bus.req_addr;
        lat_wdata <= bus.req_wdata;
      end
      if (state == RCMD) begin
        cnt <= 8'd0;
      end else if (state == WAIT && !wait_hit && !wait_expire) begin
        cnt <= cnt + 8'd1;
      end
      // Response fields only change on entry to RESP, so they hold between responses.
      if (wait_hit) begin
        rdata_q   <= bus.ram_dout;
        timeout_q <= 1'b0;
      end else if (wait_expire || state == DATA) begin
        rdata_q   <= '0;
        timeout_q <= wait_expire;
      end
    end
  end

  assign bus.rsp_rdata   = rdata_q;
  assign bus.rsp_timeout = timeout_q;

endmodule

// File: tb/tb_ram_cmd_master.sv
// Directed bench for ram_cmd_master: vector table of transactions plus back-to-back, reset-in-WAIT and stale-reply cases.
// A small command-decoding RAM model answers reads a programmable number of WAIT cycles after the read trigger.
module tb_ram_cmd_master;
  localparam int AW = 8;
  localparam int TO = 15;

  typedef struct {
    logic       wr;
    logic [7:0] addr;
    logic [7:0] wdata;
    int         k;       // WAIT cycle index of the RAM reply; 255 = never
    logic [9:0] c0;
    logic [9:0] c1;
    int         lat;     // cycle after accept holding rsp_valid
    logic [7:0] rdata;
    logic       to;
  } vec_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  int   tests = 0;
  int   fails = 0;

  ram_cmd_master_if #(.ADDR_SIZE(AW)) bus();
  ram_cmd_master #(.ADDR_SIZE(AW), .TIMEOUT(TO)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  bit   [7:0] mem [256];
  logic [7:0] waddr      = 8'h00;
  logic [7:0] raddr      = 8'h00;
  logic [7:0] dout_r     = 8'h00;
  logic       tx_r       = 1'b0;
  logic       pend       = 1'b0;
  int         pend_cnt   = 0;
  int         reply_wait = 0;

  assign bus.ram_tx_valid = tx_r;
  assign bus.ram_dout     = dout_r;

  // Reply stays asserted (with old data) until the next read trigger.
  always @(negedge clk) begin
    if (bus.ram_rx_valid === 1'b1) begin
      case (bus.ram_din[9:8])
        2'b00:   waddr = bus.ram_din[7:0];
        2'b01:   mem[waddr] = bus.ram_din[7:0];
        2'b10:   raddr = bus.ram_din[7:0];
        default: begin
          tx_r     = 1'b0;
          pend     = 1'b1;
          pend_cnt = reply_wait;
        end
      endcase
    end else if (pend) begin
      if (pend_cnt == 0) begin
        tx_r   = 1'b1;
        dout_r = mem[raddr];
        pend   = 1'b0;
      end else begin
        pend_cnt--;
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Called at a negedge with the DUT idle; returns at the negedge after the response.
  task automatic run_txn(input vec_t v, input string tag);
    logic [9:0] cmds [2];
    int ncmd;
    int cyc;
    cmds[0] = '0;
    cmds[1] = '0;
    ncmd = 0;
    reply_wait = v.k;
    check({tag, ".ready"}, 32'(bus.req_ready), 32'd1);
    bus.req_valid = 1'b1;
    bus.req_write = v.wr;
    bus.req_addr  = v.addr;
    bus.req_wdata = v.wdata;
    @(posedge clk);
    @(negedge clk);
    bus.req_valid = 1'b0;
    bus.req_wdata = 8'h00;
    cyc = 1;
    while (bus.rsp_valid !== 1'b1 && cyc < 60) begin
      if (bus.ram_rx_valid === 1'b1) begin
        if (ncmd < 2) cmds[ncmd] = bus.ram_din;
        ncmd++;
      end
      @(negedge clk);
      cyc++;
    end
    check({tag, ".lat"},     32'(cyc),             32'(v.lat));
    check({tag, ".ncmd"},    32'(ncmd),            32'd2);
    check({tag, ".cmd0"},    32'(cmds[0]),         32'(v.c0));
    check({tag, ".cmd1"},    32'(cmds[1]),         32'(v.c1));
    check({tag, ".rdata"},   32'(bus.rsp_rdata),   32'(v.rdata));
    check({tag, ".timeout"}, 32'(bus.rsp_timeout), 32'(v.to));
    @(negedge clk);
    check({tag, ".pulse"},   32'(bus.rsp_valid),   32'd0);
    check({tag, ".hold"},    32'(bus.rsp_rdata),   32'(v.rdata));
  endtask

  vec_t       vecs [10];
  vec_t       rv;
  logic       b2b_rx  [8];
  logic [9:0] b2b_din [8];
  logic       b2b_rv  [8];
  logic       b2b_rdy [8];
  int         stray;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    //          wr    addr   wdata  k    c0       c1       lat rdata  to
    vecs[0] = '{1'b1, 8'h3C, 8'hA5, 0,   10'h03C, 10'h1A5, 3,  8'h00, 1'b0};
    vecs[1] = '{1'b0, 8'h3C, 8'h00, 0,   10'h23C, 10'h300, 4,  8'hA5, 1'b0};
    vecs[2] = '{1'b1, 8'h00, 8'hFF, 0,   10'h000, 10'h1FF, 3,  8'h00, 1'b0};
    vecs[3] = '{1'b1, 8'hFF, 8'h01, 0,   10'h0FF, 10'h101, 3,  8'h00, 1'b0};
    vecs[4] = '{1'b0, 8'h00, 8'h00, 3,   10'h200, 10'h300, 7,  8'hFF, 1'b0};
    vecs[5] = '{1'b0, 8'hFF, 8'h00, 14,  10'h2FF, 10'h300, 18, 8'h01, 1'b0};
    vecs[6] = '{1'b0, 8'h3C, 8'h00, 255, 10'h23C, 10'h300, 18, 8'h00, 1'b1};
    vecs[7] = '{1'b0, 8'hFF, 8'h00, 0,   10'h2FF, 10'h300, 4,  8'h01, 1'b0};
    vecs[8] = '{1'b1, 8'h3C, 8'h5A, 0,   10'h03C, 10'h15A, 3,  8'h00, 1'b0};
    vecs[9] = '{1'b0, 8'h3C, 8'h00, 1,   10'h23C, 10'h300, 5,  8'h5A, 1'b0};

    // Write 0x10<-0x77 then read 0x10 with req_valid held high throughout.
    b2b_rx  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    b2b_din = '{10'h010, 10'h177, 10'h000, 10'h000, 10'h210, 10'h300, 10'h000, 10'h000};
    b2b_rv  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    b2b_rdy = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};

    bus.req_valid = 1'b0;
    bus.req_write = 1'b0;
    bus.req_addr  = 8'h00;
    bus.req_wdata = 8'h00;
    #1 rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("rst.ready",   32'(bus.req_ready),    32'd1);
    check("rst.rsp_vld", 32'(bus.rsp_valid),    32'd0);
    check("rst.rdata",   32'(bus.rsp_rdata),    32'd0);
    check("rst.timeout", 32'(bus.rsp_timeout),  32'd0);
    check("rst.rx_vld",  32'(bus.ram_rx_valid), 32'd0);
    check("rst.din",     32'(bus.ram_din),      32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 10; i++) begin
      run_txn(vecs[i], $sformatf("vec%0d", i));
    end

    reply_wait    = 0;
    bus.req_valid = 1'b1;
    bus.req_write = 1'b1;
    bus.req_addr  = 8'h10;
    bus.req_wdata = 8'h77;
    @(posedge clk);
    @(negedge clk);
    bus.req_write = 1'b0;
    for (int c = 0; c < 8; c++) begin
      check($sformatf("b2b.c%0d.rx_vld", c + 1), 32'(bus.ram_rx_valid), 32'(b2b_rx[c]));
      check($sformatf("b2b.c%0d.din", c + 1),    32'(bus.ram_din),      32'(b2b_din[c]));
      check($sformatf("b2b.c%0d.rsp_vld", c + 1), 32'(bus.rsp_valid),   32'(b2b_rv[c]));
      check($sformatf("b2b.c%0d.ready", c + 1),  32'(bus.req_ready),    32'(b2b_rdy[c]));
      if (c == 4) bus.req_valid = 1'b0;
      if (c == 7) check("b2b.rdata", 32'(bus.rsp_rdata), 32'h77);
      @(negedge clk);
    end

    // Read that never gets a reply, reset in its third WAIT cycle.
    reply_wait    = 255;
    bus.req_valid = 1'b1;
    bus.req_write = 1'b0;
    bus.req_addr  = 8'h3C;
    @(posedge clk);
    @(negedge clk);
    bus.req_valid = 1'b0;
    for (int c = 1; c < 5; c++) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("rstw.ready",   32'(bus.req_ready),    32'd1);
    check("rstw.rsp_vld", 32'(bus.rsp_valid),    32'd0);
    check("rstw.rdata",   32'(bus.rsp_rdata),    32'd0);
    check("rstw.rx_vld",  32'(bus.ram_rx_valid), 32'd0);
    check("rstw.din",     32'(bus.ram_din),      32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    stray = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (bus.rsp_valid === 1'b1) stray++;
    end
    check("rstw.no_rsp", 32'(stray), 32'd0);
    rv = '{1'b0, 8'h3C, 8'h00, 0, 10'h23C, 10'h300, 4, 8'h5A, 1'b0};
    run_txn(rv, "rstw.read");

    // Previous reply (0x5A) is still asserted; a read of 0x00 answering late must return 0xFF.
    check("stale.tx_high", 32'(bus.ram_tx_valid), 32'd1);
    rv = '{1'b0, 8'h00, 8'h00, 2, 10'h200, 10'h300, 6, 8'hFF, 1'b0};
    run_txn(rv, "stale");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
